uart_tx_periph: RTL and testbench

Memory-mapped UART transmitter that sits on the CPU data bus beside main memory, downstream of the CPU's bus master port. It decodes a small register window, queues bytes written by software in a FIFO, and serialises them on `o_tx` as 8N1 frames at a programmable baud divisor. The SoC top uses `o_sel` to steer `o_bus_read_data` onto the shared read-data bus.

---
 rtl/uart_tx_periph.sv | 190 +++++++++++++++++++
 tb/tb_uart_tx_periph.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter: register window decode, TX byte FIFO,
// programmable baud divisor and a start/data/stop serialiser.
module uart_tx_periph #(
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic        clk,
  input  logic        i_reset,
  input  logic [31:0] i_bus_address,
  input  logic [31:0] i_bus_wr_data,
  input  logic        i_bus_wr_enable,
  input  logic [2:0]  i_bus_write_length,
  output logic [31:0] o_bus_read_data,
  output logic        o_sel,
  output logic        o_tx
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [4:0]  DEPTH_C = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] per_q, per_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  sh_q, sh_d;
  logic        tx_q, tx_d;
  logic        pop;
  logic        bit_end;

  logic [3:0]  offset;
  logic        wr_acc, push, div_wr;
  logic [15:0] div_q, div_raw, div_new;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [4:0]    count;
  logic          full, empty;
  logic [7:0]    head;

  logic unused_wdata;
  assign unused_wdata = ^i_bus_wr_data[31:16];

  // Bus decode
  assign offset = i_bus_address[3:0];
  assign o_sel  = (i_bus_address[31:4] == BASE_ADDR[31:4]);
  assign wr_acc = o_sel && i_bus_wr_enable;
  assign div_wr = wr_acc && (offset == 4'h8);

  // FIFO; full is judged on the pre-edge count so a push while full is lost
  assign full  = (count == DEPTH_C);
  assign empty = (count == 5'd0);
  assign push  = wr_acc && (offset == 4'h0) && !full;
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= i_bus_wr_data[7:0];
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase
    end
  end

  // Divisor register; a zero result is clamped to one
  assign div_raw = (i_bus_write_length == 3'd1) ? {div_q[15:8], i_bus_wr_data[7:0]}
                                                : i_bus_wr_data[15:0];
  assign div_new = (div_raw == 16'd0) ? 16'd1 : div_raw;

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) div_q <= DEFAULT_DIV;
    else if (div_wr) div_q <= div_new;
  end

  // Serialiser
  assign bit_end = (cnt_q == 16'd1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    per_d   = per_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          sh_d    = head;
          per_d   = div_q;
          cnt_d   = div_q;
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = per_q;
          idx_d   = 3'd0;
          tx_d    = sh_q[0];
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = per_q;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            sh_d = {1'b0, sh_q[7:1]};
            tx_d = sh_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          // Back-to-back frames: reload directly into START with no idle bit
          if (!empty) begin
            pop     = 1'b1;
            sh_d    = head;
            per_d   = div_q;
            cnt_d   = div_q;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      per_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      per_q   <= per_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  assign o_tx = tx_q;

  // Register read mux
  always_comb begin
    o_bus_read_data = '0;
    if (o_sel) begin
      case (offset)
        4'h4:    o_bus_read_data = {23'd0, count, 1'b0, empty, full, (state_q != IDLE)};
        4'h8:    o_bus_read_data = {16'd0, div_q};
        default: o_bus_read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_periph.sv
// Self-checking bench for uart_tx_periph: register vector table, directed frame
// sequences and randomised bus traffic against a frame-schedule reference model.
module tb_uart_tx_periph;

  localparam logic [31:0] BASE  = 32'h0001_0000;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata;
  logic        wen;
  logic [2:0]  len;
  logic [31:0] rdata;
  logic        sel, tx;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_periph #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (DEPTH),
    .DEFAULT_DIV(16'd434)
  ) dut (
    .clk               (clk),
    .i_reset           (rst_n),
    .i_bus_address     (addr),
    .i_bus_wr_data     (wdata),
    .i_bus_wr_enable   (wen),
    .i_bus_write_length(len),
    .o_bus_read_data   (rdata),
    .o_sel             (sel),
    .o_tx              (tx)
  );

  // Reference model: pending byte queue plus the schedule of the frame on the wire
  logic [7:0]  mq[$];
  bit          m_active;
  int          m_s, m_d, m_cyc;
  logic [7:0]  m_byte;
  logic [15:0] m_div;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_reset();
    mq.delete();
    m_active = 1'b0;
    m_div    = 16'd434;
    m_cyc    = 0;
    m_s      = 0;
    m_d      = 1;
    m_byte   = 8'd0;
  endtask

  function automatic logic m_sel(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic m_tx();
    int k;
    if (!m_active) return 1'b1;
    k = (m_cyc - m_s) / m_d;
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return m_byte[k-1];
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    int n;
    n = mq.size();
    if (!m_sel(a)) return 32'd0;
    case (a[3:0])
      4'h4:    return {23'd0, 5'(n), 1'b0, n == 0, n == DEPTH, m_active};
      4'h8:    return {16'd0, m_div};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_step(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    int n;
    bit pop, push;
    logic [15:0] nd;
    n = m_cyc + 1;
    if (m_active && n == m_s + 10 * m_d) m_active = 1'b0;
    pop  = !m_active && mq.size() > 0;
    push = w && m_sel(a) && a[3:0] == 4'h0 && mq.size() < DEPTH;
    if (pop) begin
      m_byte   = mq.pop_front();
      m_s      = n;
      m_d      = int'(m_div);
      m_active = 1'b1;
    end
    if (push) mq.push_back(d[7:0]);
    if (w && m_sel(a) && a[3:0] == 4'h8) begin
      nd    = (l == 3'd1) ? {m_div[15:8], d[7:0]} : d[15:0];
      m_div = (nd == 16'd0) ? 16'd1 : nd;
    end
    m_cyc = n;
  endtask

  // One bus cycle: check state after the last edge, drive, check comb reads, advance model
  task automatic bus_cycle(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] l);
    @(negedge clk);
    chk("tx_model", {31'd0, tx}, {31'd0, m_tx()});
    addr  = a;
    wdata = d;
    wen   = w;
    len   = l;
    #1;
    chk("sel_model", {31'd0, sel}, {31'd0, m_sel(a)});
    chk("rd_model", rdata, m_rd(a));
    m_step(w, a, d, l);
  endtask

  task automatic idle_rd(input logic [31:0] a);
    bus_cycle(1'b0, a, 32'd0, 3'd4);
  endtask

  task automatic do_reset();
    wen   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
  endtask

  typedef struct {
    logic        do_wr;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [2:0]  wl;
    logic [31:0] ra;
    logic        exp_sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic w, input logic [31:0] wa, input logic [31:0] wd,
                              input logic [2:0] wl, input logic [31:0] ra,
                              input logic es, input logic [31:0] er);
    vec_t v;
    v.do_wr = w; v.wa = wa; v.wd = wd; v.wl = wl; v.ra = ra; v.exp_sel = es; v.exp_rd = er;
    return v;
  endfunction

  logic [2:0]  lens [3]  = '{3'd1, 3'd2, 3'd4};
  logic [3:0]  offs [4]  = '{4'h4, 4'hC, 4'h1, 4'h9};
  logic [31:0] raddr [6] = '{32'h0001_0000, 32'h0001_0004, 32'h0001_0008,
                             32'h0001_000C, 32'h0001_0014, 32'h0002_0004};

  logic [9:0]  fr;
  logic [31:0] rd32;
  int unsigned r;
  logic [31:0] dr;
  logic [15:0] dv;

  initial begin
    addr = '0; wdata = '0; wen = 1'b0; len = 3'd4; rst_n = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    tbl[0]  = mk(1'b0, 32'd0,         32'd0,          3'd4, BASE + 32'h4,  1'b1, 32'h4);
    tbl[1]  = mk(1'b0, 32'd0,         32'd0,          3'd4, BASE + 32'h8,  1'b1, 32'd434);
    tbl[2]  = mk(1'b1, BASE + 32'h8,  32'h0000_0100,  3'd4, BASE + 32'h8,  1'b1, 32'h100);
    tbl[3]  = mk(1'b1, BASE + 32'h8,  32'h0000_12FF,  3'd1, BASE + 32'h8,  1'b1, 32'h1FF);
    tbl[4]  = mk(1'b1, BASE + 32'h8,  32'h0000_0000,  3'd4, BASE + 32'h8,  1'b1, 32'h1);
    tbl[5]  = mk(1'b1, BASE + 32'h8,  32'hFFFF_0007,  3'd2, BASE + 32'h8,  1'b1, 32'h7);
    tbl[6]  = mk(1'b1, BASE + 32'h8,  32'h0000_0A00,  3'd1, BASE + 32'h8,  1'b1, 32'h1);
    tbl[7]  = mk(1'b0, 32'd0,         32'd0,          3'd4, BASE + 32'hC,  1'b1, 32'h0);
    tbl[8]  = mk(1'b0, 32'd0,         32'd0,          3'd4, BASE + 32'h14, 1'b0, 32'h0);
    tbl[9]  = mk(1'b0, 32'd0,         32'd0,          3'd4, BASE,          1'b1, 32'h0);
    tbl[10] = mk(1'b1, BASE + 32'h4,  32'hFFFF_FFFF,  3'd4, BASE + 32'h4,  1'b1, 32'h4);
    tbl[11] = mk(1'b1, BASE + 32'h10, 32'h0000_0055,  3'd4, BASE + 32'h4,  1'b1, 32'h4);
    tbl[12] = mk(1'b1, BASE + 32'h2,  32'h0000_1234,  3'd2, BASE + 32'h8,  1'b1, 32'h1);
    tbl[13] = mk(1'b0, 32'd0,         32'd0,          3'd4, 32'h0002_0008, 1'b0, 32'h0);

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].do_wr) bus_cycle(1'b1, tbl[i].wa, tbl[i].wd, tbl[i].wl);
      idle_rd(tbl[i].ra);
      chk($sformatf("tbl%0d_sel", i), {31'd0, sel}, {31'd0, tbl[i].exp_sel});
      chk($sformatf("tbl%0d_rd", i), rdata, tbl[i].exp_rd);
    end
    for (int i = 0; i < 5; i++) begin
      idle_rd(BASE + 32'h4);
      chk("decode_no_frame", {31'd0, tx}, 32'd1);
    end

    // Single 0x55 frame at divisor 4
    bus_cycle(1'b1, BASE + 32'h8, 32'd4, 3'd4);
    bus_cycle(1'b1, BASE, 32'h55, 3'd4);
    idle_rd(BASE + 32'h4);
    chk("single_latency_tx", {31'd0, tx}, 32'd1);
    chk("single_queued_status", rdata, 32'h10);
    fr = {1'b1, 8'h55, 1'b0};
    for (int j = 0; j < 40; j++) begin
      idle_rd(BASE + 32'h4);
      chk($sformatf("single_bit_c%0d", j), {31'd0, tx}, {31'd0, fr[j/4]});
      if (j == 39) chk("single_busy_end", rdata, 32'h5);
    end
    idle_rd(BASE + 32'h4);
    chk("single_idle_status", rdata, 32'h4);
    chk("single_idle_tx", {31'd0, tx}, 32'd1);

    // Overflow: six pushes, sixth dropped, five frames back to back
    bus_cycle(1'b1, BASE + 32'h8, 32'd16, 3'd4);
    for (int b = 0; b < 6; b++) bus_cycle(1'b1, BASE, 32'hA1 + 32'(b), 3'd4);
    for (int i = 1; i <= 797; i++) begin
      idle_rd(BASE + 32'h4);
      if (i == 1) chk("ovf_full_status", rdata, 32'h43);
      chk("ovf_busy", {31'd0, rdata[0]}, {31'd0, i < 797});
      if (i == 797) chk("ovf_drain_status", rdata, 32'h4);
    end

    // Divisor change mid-frame: frame 1 at 3 clocks/bit, frame 2 at 5
    bus_cycle(1'b1, BASE + 32'h8, 32'd3, 3'd4);
    bus_cycle(1'b1, BASE, 32'hC3, 3'd4);
    bus_cycle(1'b1, BASE, 32'h3C, 3'd4);
    bus_cycle(1'b1, BASE + 32'h8, 32'd5, 3'd4);
    for (int i = 1; i <= 80; i++) begin
      idle_rd(BASE + 32'h4);
      if (i == 79) chk("divchg_busy_before", {31'd0, rdata[0]}, 32'd1);
      if (i == 80) chk("divchg_busy_after", {31'd0, rdata[0]}, 32'd0);
    end

    // Reset during data bit 3 with another byte queued
    bus_cycle(1'b1, BASE + 32'h8, 32'd4, 3'd4);
    bus_cycle(1'b1, BASE, 32'h00, 3'd4);
    bus_cycle(1'b1, BASE, 32'h77, 3'd4);
    for (int i = 1; i <= 18; i++) idle_rd(BASE + 32'h4);
    chk("midrst_bit3_low", {31'd0, tx}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx_async", {31'd0, tx}, 32'd1);
    chk("midrst_status_in_reset", rdata, 32'h4);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    for (int i = 0; i < 60; i++) idle_rd(BASE + 32'h4);
    chk("midrst_status_after", rdata, 32'h4);
    idle_rd(BASE + 32'h8);
    chk("midrst_div_after", rdata, 32'd434);

    // Randomised traffic
    do_reset();
    bus_cycle(1'b1, BASE + 32'h8, 32'd2, 3'd4);
    for (int c = 0; c < 3000; c++) begin
      r  = $urandom_range(0, 99);
      dr = $urandom;
      if (r < 30) begin
        bus_cycle(1'b1, BASE, dr, 3'd4);
      end else if (r < 35) begin
        dv = 16'($urandom_range(0, 5));
        bus_cycle(1'b1, BASE + 32'h8, {dr[31:16], dv}, lens[$urandom_range(0, 2)]);
      end else if (r < 40) begin
        bus_cycle(1'b1, BASE + {28'd0, offs[$urandom_range(0, 3)]}, dr, 3'd4);
      end else if (r < 45) begin
        bus_cycle(1'b1, BASE + 32'h10, dr, 3'd4);
      end else begin
        idle_rd(raddr[$urandom_range(0, 5)]);
      end
    end
    idle_rd(BASE + 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
